// File: rtl/alu_issue_unit.sv
// Issue/writeback stage for the registered 32-bit ALU.
// Holds a 16-entry register file and accepts one R-type instruction at a time.
// Each instruction reads its operands, waits for the ALU's clocked result and
// writes it back. The unit takes four cycles per instruction.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | accept an instruction or a preload; reject an illegal funct
// ISSUE | drive ALU operands from rf[rs], rf[rt], shamt and funct
// EXEC  | the ALU samples its inputs on the edge that leaves this state
// WB    | write alu_res to rf[rd] and pulse done
module alu_issue_unit #(
  parameter int DW = 32,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [31:0]   instr,
  input  logic          ld_en,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_data,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [4:0]    alu_shamt,
  output logic [3:0]    alu_funct,
  input  logic [DW-1:0] alu_res,
  output logic          done,
  output logic [AW-1:0] wb_addr,
  output logic [DW-1:0] wb_data,
  output logic          err,
  input  logic [AW-1:0] dbg_addr,
  output logic [DW-1:0] dbg_data
);

  typedef enum logic [1:0] {IDLE, ISSUE, EXEC, WB} state_t;

  state_t        state;
  logic [DW-1:0] rf [2**AW];

  logic [3:0]    funct_q;
  logic [AW-1:0] rd_q;
  logic [AW-1:0] rs_q;
  logic [AW-1:0] rt_q;
  logic [4:0]    shamt_q;

  logic [3:0]    in_funct;
  logic          in_legal;
  logic          accept;
  logic          unused_instr;

  assign in_funct = instr[31:28];
  assign in_legal = (in_funct != 4'd0) && (in_funct <= 4'd9);
  assign in_ready = (state == IDLE) && !ld_en;
  assign accept   = in_valid && in_ready;

  // instr[10:0] carries no meaning for R-type instructions
  assign unused_instr = ^instr[10:0];

  // register 0 is hardwired to zero on the debug port as well
  assign dbg_data = (dbg_addr == '0) ? '0 : rf[dbg_addr];

  // sequencing FSM, register file and registered ALU/writeback outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      for (int i = 0; i < 2**AW; i++) rf[i] <= '0;
      funct_q   <= '0;
      rd_q      <= '0;
      rs_q      <= '0;
      rt_q      <= '0;
      shamt_q   <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_shamt <= '0;
      alu_funct <= '0;
      wb_addr   <= '0;
      wb_data   <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          // in_ready is low while ld_en is high, so accept and load never coincide
          if (ld_en && (ld_addr != '0)) rf[ld_addr] <= ld_data;
          if (accept) begin
            funct_q <= in_funct;
            rd_q    <= instr[24 +: AW];
            rs_q    <= instr[20 +: AW];
            rt_q    <= instr[16 +: AW];
            shamt_q <= instr[15:11];
            if (in_legal) state <= ISSUE;
            else          err   <= 1'b1;
          end
        end
        ISSUE: begin
          alu_a     <= (rs_q == '0) ? '0 : rf[rs_q];
          alu_b     <= (rt_q == '0) ? '0 : rf[rt_q];
          alu_shamt <= shamt_q;
          alu_funct <= funct_q;
          state     <= EXEC;
        end
        EXEC: begin
          state <= WB;
        end
        WB: begin
          if (rd_q != '0) rf[rd_q] <= alu_res;
          wb_addr <= rd_q;
          wb_data <= alu_res;
          done    <= 1'b1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_unit.sv
// Self-checking bench for alu_issue_unit: a stand-in registered ALU, a
// register-file reference model and a scoreboard drained by a monitor.
module tb_alu_issue_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic        ld_en;
  logic [3:0]  ld_addr;
  logic [31:0] ld_data;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [4:0]  alu_shamt;
  logic [3:0]  alu_funct;
  logic [31:0] alu_res;
  logic        done;
  logic [3:0]  wb_addr;
  logic [31:0] wb_data;
  logic        err;
  logic [3:0]  dbg_addr;
  logic [31:0] dbg_data;

  alu_issue_unit #(.DW(32), .AW(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_shamt(alu_shamt), .alu_funct(alu_funct),
    .alu_res(alu_res), .done(done), .wb_addr(wb_addr), .wb_data(wb_data),
    .err(err), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [3:0]  addr;
    logic [31:0] data;
    int          cyc;
  } wb_exp_t;

  typedef struct {
    logic [3:0] funct;
    int         cyc;
  } err_exp_t;

  wb_exp_t  sbq[$];
  err_exp_t errq[$];

  logic [31:0] model_rf [16];
  logic [3:0]  exp_funct;

  // Behaviour of the team ALU: shift amount 0 means "shift by b[0]";
  // funct 8 is the logical right shift and funct 9 the sign-filling one.
  function automatic logic [31:0] alu_fn(logic [31:0] a, logic [31:0] b,
                                         logic [4:0] sh, logic [3:0] f);
    int amt;
    logic [31:0] r;
    amt = (sh == 5'd0) ? int'(b[0]) : int'(sh);
    case (f)
      4'd1: r = a + b;
      4'd2: r = a - b;
      4'd3: r = a & b;
      4'd4: r = a | b;
      4'd5: r = a ^ b;
      4'd6: r = ~a;
      4'd7: r = a << amt;
      4'd8: r = a >> amt;
      4'd9: r = $signed(a) >>> amt;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  // stand-in for the registered ALU
  always @(posedge clk) alu_res <= alu_fn(alu_a, alu_b, alu_shamt, alu_funct);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk(int f, int rd, int rs, int rt, int sh);
    logic [31:0] w;
    w = 32'd0;
    w[31:28] = 4'(f);
    w[27:24] = 4'(rd);
    w[23:20] = 4'(rs);
    w[19:16] = 4'(rt);
    w[15:11] = 5'(sh);
    return w;
  endfunction

  // monitor: pops the scoreboard whenever done or err is seen
  always @(negedge clk) begin
    if (rst !== 1'b1) begin
      chk("done_err_exclusive", {31'd0, done & err}, 32'd0);
      if (done === 1'b1) begin
        if (sbq.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_done actual=1 expected=0 (t=%0t)", $time);
        end else begin
          wb_exp_t e;
          e = sbq.pop_front();
          chk("wb_addr", {28'd0, wb_addr}, {28'd0, e.addr});
          chk("wb_data", wb_data, e.data);
          chk("done_latency", cyc, e.cyc);
        end
      end
      if (err === 1'b1) begin
        if (errq.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_err actual=1 expected=0 (t=%0t)", $time);
        end else begin
          err_exp_t e;
          e = errq.pop_front();
          chk("err_cycle", cyc, e.cyc);
          chk("err_alu_funct_hold", {28'd0, alu_funct}, {28'd0, e.funct});
        end
      end
    end
  end

  task automatic load(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    #1 chk("ld_blocks_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    #1 ld_en = 1'b0;
    if (a != 4'd0) model_rf[a] = d;
  endtask

  task automatic issue(input logic [31:0] iw);
    int n;
    logic [3:0] f, rd, rs, rt;
    logic [4:0] sh;
    logic [31:0] res;
    bit legal;
    n = 0;
    @(negedge clk);
    in_valid = 1'b1; instr = iw;
    while (in_ready !== 1'b1 && n < 20) begin
      @(negedge clk); n++;
    end
    if (in_ready !== 1'b1) begin
      checks++; failures++;
      $display("FAIL accept_timeout actual=%b expected=1", in_ready);
      in_valid = 1'b0;
      return;
    end
    f = iw[31:28]; rd = iw[27:24]; rs = iw[23:20]; rt = iw[19:16]; sh = iw[15:11];
    legal = (f >= 4'd1) && (f <= 4'd9);
    if (legal) begin
      res = alu_fn(model_rf[rs], model_rf[rt], sh, f);
      sbq.push_back('{addr: rd, data: res, cyc: cyc + 4});
      if (rd != 4'd0) model_rf[rd] = res;
      exp_funct = f;
    end else begin
      errq.push_back('{funct: exp_funct, cyc: cyc + 1});
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    instr = $urandom;
    if (legal) begin
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        chk("in_ready_busy", {31'd0, in_ready}, 32'd0);
      end
    end
    @(negedge clk);
    chk("in_ready_back", {31'd0, in_ready}, 32'd1);
  endtask

  task automatic sweep_rf(input string name);
    for (int i = 0; i < 16; i++) begin
      dbg_addr = 4'(i);
      #1 chk(name, dbg_data, model_rf[i]);
    end
  endtask

  task automatic chk_reset_outputs();
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_alu_b", alu_b, 32'd0);
    chk("rst_alu_shamt", {27'd0, alu_shamt}, 32'd0);
    chk("rst_alu_funct", {28'd0, alu_funct}, 32'd0);
    chk("rst_wb_addr", {28'd0, wb_addr}, 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; instr = 32'd0; ld_en = 1'b0;
    ld_addr = 4'd0; ld_data = 32'd0; dbg_addr = 4'd0;
    for (int i = 0; i < 16; i++) model_rf[i] = 32'd0;
    exp_funct = 4'd0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    #1 chk_reset_outputs();
    sweep_rf("rst_rf");

    // basic arithmetic
    load(4'd1, 32'd5);
    load(4'd2, 32'd3);
    issue(mk(1, 3, 1, 2, 0));
    dbg_addr = 4'd3;
    #1 chk("dbg_add_r3", dbg_data, 32'd8);
    issue(mk(2, 4, 2, 1, 0));
    dbg_addr = 4'd4;
    #1 chk("dbg_sub_r4", dbg_data, 32'hFFFF_FFFE);
    issue(mk(5, 5, 1, 2, 0));
    dbg_addr = 4'd5;
    #1 chk("dbg_xor_r5", dbg_data, 32'h0000_0006);

    // shifts
    load(4'd1, 32'h8000_0000);
    issue(mk(8, 6, 1, 2, 4));
    dbg_addr = 4'd6;
    #1 chk("dbg_shift8", dbg_data, 32'h0800_0000);
    issue(mk(9, 7, 1, 2, 4));
    dbg_addr = 4'd7;
    #1 chk("dbg_shift9", dbg_data, 32'hF800_0000);
    issue(mk(7, 8, 1, 2, 1));
    dbg_addr = 4'd8;
    #1 chk("dbg_shift7", dbg_data, 32'h0000_0000);

    // illegal funct: err only, nothing else moves
    issue(mk(12, 9, 1, 2, 0));
    chk("illegal_alu_funct", {28'd0, alu_funct}, 32'd7);
    sweep_rf("illegal_rf");

    // writes to register 0 are dropped
    load(4'd1, 32'd5);
    issue(mk(1, 0, 1, 2, 0));
    dbg_addr = 4'd0;
    #1 chk("dbg_r0_after_wb", dbg_data, 32'd0);
    load(4'd0, 32'hDEAD_BEEF);
    dbg_addr = 4'd0;
    #1 chk("dbg_r0_after_ld", dbg_data, 32'd0);
    sweep_rf("pre_rst_rf");

    // reset in EXEC aborts the instruction
    @(negedge clk);
    in_valid = 1'b1; instr = mk(1, 10, 1, 2, 0);
    #1 chk("rst_test_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) model_rf[i] = 32'd0;
    exp_funct = 4'd0;
    #1 chk_reset_outputs();
    repeat (4) @(negedge clk);
    chk("rst_no_done", {31'd0, done}, 32'd0);
    sweep_rf("rst_mid_rf");
    load(4'd11, 32'h1234_5678);

    // randomized traffic
    for (int i = 1; i < 16; i++) load(4'(i), $urandom);
    for (int k = 0; k < 200; k++) begin
      logic [31:0] w;
      if ($urandom_range(0, 9) < 3) load(4'($urandom_range(0, 15)), $urandom);
      w = $urandom;
      if ($urandom_range(0, 4) != 0) w[31:28] = 4'($urandom_range(1, 9));
      if ($urandom_range(0, 7) == 0) w[15:11] = 5'd0;
      issue(w);
    end

    repeat (6) @(negedge clk);
    chk("sb_drained", sbq.size(), 32'd0);
    chk("errq_drained", errq.size(), 32'd0);
    sweep_rf("final_rf");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
